fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. It holds the program counter, drives the instruction-memory address, and predicts branches with a direct-mapped BTB plus 2-bit saturating counters. It presents PC, PC+4, instruction and prediction outputs to the fetch/decode pipeline register, and the decode/execute register carries the prediction bit on to execute. Execute-stage resolution trains the predictor and redirects on mispredict.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_branch_predictor.sv | 60 ++++++
 rtl/fetch_stage.sv | 67 ++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: reset PC default, 2-bit branch counter and BTB entry layout.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // The tag keeps pc[31:2]; the index bits always equal the slot
  // address, so comparing all of them matches comparing pc[31:IDX_W+2].
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;

endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: one combinational lookup port, one update port.
module branch_predictor
  import fetch_stage_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t btb [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  btb_entry_t       lk_entry;
  btb_entry_t       up_entry;
  logic             up_hit;
  logic             unused_low_bits;

  assign unused_low_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign up_idx   = update_pc[IDX_W+1:2];
  assign lk_entry = btb[lk_idx];
  assign up_entry = btb[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == update_pc[31:2]);

  // Lookup reads the array before the edge, so a same-cycle update is not seen.
  assign lookup_taken  = lk_entry.valid && (lk_entry.tag == lookup_pc[31:2]) && lk_entry.ctr[1];
  assign lookup_target = lk_entry.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btb[i[IDX_W-1:0]] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          if (up_entry.ctr != CTR_ST) btb[up_idx].ctr <= up_entry.ctr + 2'd1;
          btb[up_idx].target <= update_target;
        end else if (up_entry.ctr != CTR_SNT) begin
          btb[up_idx].ctr <= up_entry.ctr - 2'd1;
        end
      end else if (update_taken) begin
        btb[up_idx] <= '{valid: 1'b1, tag: update_pc[31:2], target: update_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register and next-PC selection around the branch predictor.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        redirect_e,
  input  logic [31:0] redirect_pc_e,
  input  logic        update_e,
  input  logic [31:0] update_pc_e,
  input  logic        update_taken_e,
  input  logic [31:0] update_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic [31:0] instruction_f,
  output logic        predicted_branch_f,
  output logic [31:0] predicted_target_f
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] btb_target;

  branch_predictor #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_bp (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (pc),
    .lookup_taken (predicted_branch_f),
    .lookup_target(btb_target),
    .update_en    (update_e),
    .update_pc    (update_pc_e),
    .update_taken (update_taken_e),
    .update_target(update_target_e)
  );

  assign pc_f               = pc;
  assign imem_addr          = pc;
  assign pc_plus4_f         = pc + 32'd4;
  assign instruction_f      = imem_rdata;
  assign predicted_target_f = predicted_branch_f ? btb_target : pc_plus4_f;

  always_comb begin
    next_pc = predicted_target_f;
    if (redirect_e) begin
      next_pc = redirect_pc_e;
    end else if (stall_f) begin
      next_pc = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected PCs queued at stimulus time, popped after each edge.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam int unsigned ENTRIES = 16;
  localparam logic [31:0] IMEM_K  = 32'h1357_9BDF;
  localparam logic [31:0] PC_A    = 32'h0000_0040;
  localparam logic [31:0] PC_AL   = PC_A + 4 * ENTRIES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        redirect_e = 1'b0;
  logic [31:0] redirect_pc_e = '0;
  logic        update_e = 1'b0;
  logic [31:0] update_pc_e = '0;
  logic        update_taken_e = 1'b0;
  logic [31:0] update_target_e = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] instruction_f;
  logic        predicted_branch_f;
  logic [31:0] predicted_target_f;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ IMEM_K;

  fetch_stage #(
    .RESET_PC   (RST_PC),
    .BTB_ENTRIES(ENTRIES)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_f           (stall_f),
    .redirect_e        (redirect_e),
    .redirect_pc_e     (redirect_pc_e),
    .update_e          (update_e),
    .update_pc_e       (update_pc_e),
    .update_taken_e    (update_taken_e),
    .update_target_e   (update_target_e),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .pc_f              (pc_f),
    .pc_plus4_f        (pc_plus4_f),
    .instruction_f     (instruction_f),
    .predicted_branch_f(predicted_branch_f),
    .predicted_target_f(predicted_target_f)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_f = 1'b0; redirect_e = 1'b0; update_e = 1'b0; update_taken_e = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++; if (pc_f !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_f, RST_PC); end
    checks++; if (pc_plus4_f !== RST_PC + 32'd4) begin failures++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4_f, RST_PC + 32'd4); end
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", predicted_branch_f); end
    checks++; if (predicted_target_f !== RST_PC + 32'd4) begin failures++; $display("FAIL reset_ptgt got=%h exp=%h", predicted_target_f, RST_PC + 32'd4); end
    checks++; if (instruction_f !== (RST_PC ^ IMEM_K)) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction_f, RST_PC ^ IMEM_K); end
    rst = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      exp_q.push_back(32'(i * 4));
      step();
      exp = exp_q.pop_front();
      checks++; if (pc_f !== exp) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc_f, exp); end
      checks++; if (instruction_f !== (exp ^ IMEM_K)) begin failures++; $display("FAIL seq_instr got=%h exp=%h", instruction_f, exp ^ IMEM_K); end
    end
  endtask

  task automatic test_stall();
    stall_f = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h8);
      step();
      exp = exp_q.pop_front();
      checks++; if (pc_f !== exp) begin failures++; $display("FAIL stall_hold got=%h exp=%h", pc_f, exp); end
    end
    stall_f = 1'b0;
    exp_q.push_back(32'hC);
    step();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL stall_release got=%h exp=%h", pc_f, exp); end
  endtask

  task automatic test_redirect_beats_stall();
    stall_f = 1'b1; redirect_e = 1'b1; redirect_pc_e = 32'h100;
    exp_q.push_back(32'h100);
    step();
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL redirect_stall got=%h exp=%h", pc_f, exp); end
    checks++; if (pc_plus4_f !== 32'h104) begin failures++; $display("FAIL redirect_pc4 got=%h exp=%h", pc_plus4_f, 32'h104); end
  endtask

  task automatic test_train_predict();
    // allocate 0x40 -> 0x80 while steering fetch to 0x40
    update_e = 1'b1; update_pc_e = PC_A; update_taken_e = 1'b1; update_target_e = 32'h80;
    redirect_e = 1'b1; redirect_pc_e = PC_A;
    exp_q.push_back(PC_A);
    step();
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL train_pc got=%h exp=%h", pc_f, exp); end
    checks++; if (predicted_branch_f !== 1'b1) begin failures++; $display("FAIL train_pred got=%b exp=1", predicted_branch_f); end
    checks++; if (predicted_target_f !== 32'h80) begin failures++; $display("FAIL train_ptgt got=%h exp=%h", predicted_target_f, 32'h80); end
    exp_q.push_back(32'h80);
    step();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL follow_pred got=%h exp=%h", pc_f, exp); end
    // sit on 0x40 and weaken it; same-cycle lookup must see the old counter
    redirect_e = 1'b1; redirect_pc_e = PC_A; stall_f = 1'b1;
    step();
    redirect_e = 1'b0;
    update_e = 1'b1; update_pc_e = PC_A; update_taken_e = 1'b0;
    checks++; if (predicted_branch_f !== 1'b1) begin failures++; $display("FAIL rdw_pred got=%b exp=1", predicted_branch_f); end
    step();
    step();
    idle_inputs();
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL untrain_pred got=%b exp=0", predicted_branch_f); end
    checks++; if (predicted_target_f !== PC_A + 32'd4) begin failures++; $display("FAIL untrain_ptgt got=%h exp=%h", predicted_target_f, PC_A + 32'd4); end
    exp_q.push_back(PC_A + 32'd4);
    step();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL untrain_pc got=%h exp=%h", pc_f, exp); end
  endtask

  task automatic test_alias_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    stall_f = 1'b1; redirect_e = 1'b1; redirect_pc_e = PC_A;
    update_e = 1'b1; update_pc_e = PC_A; update_taken_e = 1'b1; update_target_e = 32'h80;
    step();
    redirect_e = 1'b0;
    for (int i = 0; i < 3; i++) step();
    update_e = 1'b0;
    redirect_e = 1'b1; redirect_pc_e = PC_AL;
    step();
    redirect_e = 1'b0;
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL alias_miss got=%b exp=0", predicted_branch_f); end
    // from saturated 11, one not-taken still predicts taken
    redirect_e = 1'b1; redirect_pc_e = PC_A;
    update_e = 1'b1; update_taken_e = 1'b0;
    step();
    redirect_e = 1'b0; update_e = 1'b0;
    checks++; if (predicted_branch_f !== 1'b1) begin failures++; $display("FAIL sat_one_nt got=%b exp=1", predicted_branch_f); end
    update_e = 1'b1;
    step();
    update_e = 1'b0;
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL sat_two_nt got=%b exp=0", predicted_branch_f); end
    update_e = 1'b1; update_pc_e = PC_AL; update_taken_e = 1'b1; update_target_e = 32'h200;
    step();
    update_e = 1'b0;
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL evicted_miss got=%b exp=0", predicted_branch_f); end
    redirect_e = 1'b1; redirect_pc_e = PC_AL;
    step();
    idle_inputs();
    checks++; if (predicted_branch_f !== 1'b1) begin failures++; $display("FAIL alias_alloc got=%b exp=1", predicted_branch_f); end
    checks++; if (predicted_target_f !== 32'h200) begin failures++; $display("FAIL alias_ptgt got=%h exp=%h", predicted_target_f, 32'h200); end
    exp_q.push_back(32'h200);
    step();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL alias_follow got=%h exp=%h", pc_f, exp); end
  endtask

  task automatic test_mid_reset();
    update_e = 1'b1; update_pc_e = 32'h124; update_taken_e = 1'b1; update_target_e = 32'h300;
    step();
    rst = 1'b1; redirect_e = 1'b1; redirect_pc_e = 32'h500; stall_f = 1'b1;
    update_target_e = 32'h400;
    exp_q.push_back(RST_PC);
    step();
    rst = 1'b0;
    idle_inputs();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL midrst_pc got=%h exp=%h", pc_f, exp); end
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL midrst_pred got=%b exp=0", predicted_branch_f); end
    stall_f = 1'b1; redirect_e = 1'b1; redirect_pc_e = 32'h124;
    step();
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL midrst_upd_pc got=%b exp=0", predicted_branch_f); end
    redirect_pc_e = PC_AL;
    step();
    idle_inputs();
    checks++; if (predicted_branch_f !== 1'b0) begin failures++; $display("FAIL midrst_alias got=%b exp=0", predicted_branch_f); end
  endtask

  task automatic test_wrap();
    redirect_e = 1'b1; redirect_pc_e = 32'hFFFF_FFFC;
    step();
    idle_inputs();
    checks++; if (pc_plus4_f !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4_f); end
    exp_q.push_back(32'h0);
    step();
    exp = exp_q.pop_front();
    checks++; if (pc_f !== exp) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc_f, exp); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_beats_stall();
    test_train_predict();
    test_alias_saturation();
    test_mid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
